// File: rtl/lanzones_pkg.sv
// Shared types for the lanzones fetch path: FSM states, decode-buffer entry and reset defaults.
package lanzones_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE_GAP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries feeding decode; flush wins over push and pop in the same cycle.
module fetch_fifo
    import lanzones_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  fetch_entry_t           pushData_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output fetch_entry_t           head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          full;
    logic          doPush;
    logic          doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign doPop  = pop_i && !empty && !flush_i;
    // A pop in the same cycle makes room, so a full buffer can still accept a push.
    assign doPush = push_i && !flush_i && (!full || doPop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_q + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC sequencing, single outstanding read, buffered hand-off to decode.
// Optional FETCH_ALIGN_CHK_EN: a misaligned redirect sets sticky FErr and halts all further issue.
module fetch_unit
    import lanzones_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            LEn,
    output logic            RRdy,
    output logic [XLEN-1:0] RAddr,
    input  logic            RVld,
    input  logic [XLEN-1:0] RData,
    input  logic            RedirVld,
    input  logic [XLEN-1:0] RedirPc,
    output logic            IVld,
    input  logic            IRdy,
    output logic [XLEN-1:0] IPc,
    output logic [XLEN-1:0] IData,
    output logic            FErr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] reqPc_q;
    logic [XLEN-1:0] reqPc_d;
    logic            discard_q;
    logic            discard_d;
    logic [XLEN-1:0] redirTarget;
    logic            push;
    logic            pop;
    logic            halt;
    logic            issueOk;
    logic            fifoFull;
    logic [CW-1:0]   fifoCount;
    fetch_entry_t    pushEntry;
    fetch_entry_t    head;

    assign redirTarget = RedirPc & 32'hFFFF_FFFC;
    assign pop         = IVld && IRdy;
    assign fifoFull    = (fifoCount == CW'(FIFO_DEPTH));
    assign issueOk     = LEn && !halt && (!fifoFull || pop);
    assign pushEntry   = {reqPc_q, RData};

`ifdef FETCH_ALIGN_CHK_EN
    logic ferr_q;
    logic ferr_d;

    assign ferr_d = ferr_q || (RedirVld && (RedirPc[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign halt = ferr_q;
    assign FErr = ferr_q;
`else
    assign halt = 1'b0;
    assign FErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= RESET_PC;
            reqPc_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            reqPc_q   <= reqPc_d;
            discard_q <= discard_d;
        end
    end

    // A redirect outside REQ blocks issue for that cycle so the next request uses the new PC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        reqPc_d   = reqPc_q;
        discard_d = discard_q;
        push      = 1'b0;
        case (state_q)
            IDLE, ISSUE_GAP: begin
                if (RedirVld) begin
                    pc_d    = redirTarget;
                    state_d = IDLE;
                end else if (issueOk) begin
                    reqPc_d = pc_q;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (RVld) begin
                    state_d   = ISSUE_GAP;
                    discard_d = 1'b0;
                    if (RedirVld) begin
                        pc_d = redirTarget;
                    end else if (!discard_q) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (RedirVld) begin
                    discard_d = 1'b1;
                    pc_d      = redirTarget;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        RRdy  = (state_q == REQ);
        RAddr = {2'b00, reqPc_q[XLEN-1:2]};
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (push),
        .pushData_i(pushEntry),
        .pop_i     (pop),
        .flush_i   (RedirVld),
        .count_o   (fifoCount),
        .head_o    (head)
    );

    assign IVld  = (fifoCount != '0);
    assign IPc   = IVld ? head.pc : '0;
    assign IData = IVld ? head.instr : '0;

endmodule
